// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback/commit stage.
// CSR op codes, FSM state type, ERA CSR number and the exception
// priority -> ecode/esubcode table (index 0 = highest priority).
package wb_pkg;

  localparam logic [1:0] CSR_NONE = 2'b00;
  localparam logic [1:0] CSR_RD   = 2'b01;
  localparam logic [1:0] CSR_WR   = 2'b10;
  localparam logic [1:0] CSR_XCHG = 2'b11;

  localparam logic [13:0] CSR_ERA = 14'h6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CSRWAIT = 2'd1,
    S_COMMIT  = 2'd2
  } wb_state_e;

  // Priority slot -> ecode. Slots 6/7 are spare extension sources.
  function automatic logic [5:0] exc_ecode(input int idx);
    case (idx)
      0:       exc_ecode = 6'h00; // INT
      1:       exc_ecode = 6'h08; // ADEF
      2:       exc_ecode = 6'h0D; // INE
      3:       exc_ecode = 6'h0B; // SYS
      4:       exc_ecode = 6'h0C; // BRK
      5:       exc_ecode = 6'h09; // ALE
      6:       exc_ecode = 6'h07;
      default: exc_ecode = 6'h3F;
    endcase
  endfunction

  // None of the defined sources carry a sub-code.
  function automatic logic [8:0] exc_esubcode(input int idx);
    exc_esubcode = (idx > 7) ? 9'h1FF : 9'h000;
  endfunction

endpackage

// File: rtl/wb_commit_stage_exc_prio.sv
// wb_exc_prio: NUM_EXC-bit priority encoder; the lowest set bit selects
// ecode/esubcode from the package table.
module wb_exc_prio
  import wb_pkg::*;
#(
  parameter int NUM_EXC = 6
) (
  input  logic [NUM_EXC-1:0] i_exc,
  output logic               o_any,
  output logic [5:0]         o_ecode,
  output logic [8:0]         o_esubcode
);

  // Scan from lowest priority upward so the lowest set bit wins last.
  always_comb begin
    o_any      = |i_exc;
    o_ecode    = 6'h00;
    o_esubcode = 9'h000;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (i_exc[i]) begin
        o_ecode    = exc_ecode(i);
        o_esubcode = exc_esubcode(i);
      end
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: final pipeline stage. Holds one instruction, waits
// CSR_LAT cycles for CSR reads, then retires it: RF write, CSR write,
// exception or ertn flush. Optional macro WB_RETIRE_CNT_EN builds the
// 64-bit retired-instruction counter; otherwise retire_cnt is tied to 0.
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int NUM_EXC = 6,
  parameter int CSR_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms_to_ws_valid,
  output logic               ws_allowin,
  input  logic [PC_W-1:0]    ms_pc,
  input  logic [PC_W-1:0]    ms_result,
  input  logic [PC_W-1:0]    ms_vaddr,
  input  logic [4:0]         ms_dest,
  input  logic               ms_gr_we,
  input  logic [NUM_EXC-1:0] ms_exc,
  input  logic               ms_ertn,
  input  logic [1:0]         ms_csr_op,
  input  logic [13:0]        ms_csr_num,
  input  logic [PC_W-1:0]    ms_rj,
  input  logic [PC_W-1:0]    ms_rkd,
  output logic               csr_re,
  output logic               csr_we,
  output logic [13:0]        csr_num,
  output logic [PC_W-1:0]    csr_wmask,
  output logic [PC_W-1:0]    csr_wvalue,
  input  logic [PC_W-1:0]    csr_rvalue,
  output logic               wb_ex,
  output logic               ertn_flush,
  output logic [5:0]         wb_ecode,
  output logic [8:0]         wb_esubcode,
  output logic [PC_W-1:0]    wb_pc,
  output logic [PC_W-1:0]    wb_vaddr,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [PC_W-1:0]    rf_wdata,
  output logic [PC_W-1:0]    debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [4:0]         debug_wb_rf_wnum,
  output logic [PC_W-1:0]    debug_wb_rf_wdata,
  output logic [63:0]        retire_cnt
);

  localparam logic [1:0] LAT = 2'(CSR_LAT);

  wb_state_e          r_state;
  logic               r_valid;
  logic [1:0]         r_cnt;
  logic [PC_W-1:0]    r_pc, r_result, r_vaddr, r_rj, r_rkd;
  logic [4:0]         r_dest;
  logic               r_gr_we;
  logic [NUM_EXC-1:0] r_exc;
  logic               r_ertn;
  logic [1:0]         r_csr_op;
  logic [13:0]        r_csr_num;

  logic               w_commit, w_exc_any, w_flush, w_cap, w_csr_wait;
  logic [5:0]         w_ecode;
  logic [8:0]         w_esubcode;

  wb_exc_prio #(.NUM_EXC(NUM_EXC)) u_exc_prio (
    .i_exc      (r_exc),
    .o_any      (w_exc_any),
    .o_ecode    (w_ecode),
    .o_esubcode (w_esubcode)
  );

  assign w_commit   = (r_state == S_COMMIT);
  assign w_flush    = w_commit && (w_exc_any || r_ertn);
  assign ws_allowin = !r_valid || w_commit;
  // A flushing instruction kills whatever upstream offers alongside it.
  assign w_cap      = ms_to_ws_valid && ws_allowin && !w_flush;
  // Faulting instructions never wait on the CSR read.
  assign w_csr_wait = (ms_csr_op != CSR_NONE) && (CSR_LAT > 0) && !(|ms_exc);

  // Stage FSM and CSR latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_cnt   <= 2'd0;
    end else if (w_cap) begin
      r_valid <= 1'b1;
      if (w_csr_wait) begin
        r_state <= S_CSRWAIT;
        r_cnt   <= LAT;
      end else begin
        r_state <= S_COMMIT;
        r_cnt   <= 2'd0;
      end
    end else begin
      case (r_state)
        S_CSRWAIT: begin
          if (r_cnt == 2'd1) begin
            r_state <= S_COMMIT;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Capture all upstream fields together on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_result  <= '0;
      r_vaddr   <= '0;
      r_rj      <= '0;
      r_rkd     <= '0;
      r_dest    <= '0;
      r_gr_we   <= 1'b0;
      r_exc     <= '0;
      r_ertn    <= 1'b0;
      r_csr_op  <= CSR_NONE;
      r_csr_num <= '0;
    end else if (w_cap) begin
      r_pc      <= ms_pc;
      r_result  <= ms_result;
      r_vaddr   <= ms_vaddr;
      r_rj      <= ms_rj;
      r_rkd     <= ms_rkd;
      r_dest    <= ms_dest;
      r_gr_we   <= ms_gr_we;
      r_exc     <= ms_exc;
      r_ertn    <= ms_ertn;
      r_csr_op  <= ms_csr_op;
      r_csr_num <= ms_csr_num;
    end
  end

  // CSR port: read address held for the whole residency, write only at commit.
  assign csr_re     = r_valid && ((r_csr_op != CSR_NONE) || r_ertn);
  assign csr_num    = r_ertn ? CSR_ERA : r_csr_num;
  assign csr_we     = w_commit && !w_exc_any && ((r_csr_op == CSR_WR) || (r_csr_op == CSR_XCHG));
  assign csr_wmask  = (r_csr_op == CSR_XCHG) ? r_rj : {PC_W{1'b1}};
  assign csr_wvalue = r_rkd;

  assign wb_ex       = w_commit && w_exc_any;
  assign ertn_flush  = w_commit && r_ertn && !w_exc_any;
  assign wb_ecode    = w_ecode;
  assign wb_esubcode = w_esubcode;
  assign wb_pc       = r_pc;
  assign wb_vaddr    = r_vaddr;

  assign rf_we    = r_gr_we && w_commit && !w_exc_any;
  assign rf_waddr = r_dest;
  assign rf_wdata = (r_csr_op != CSR_NONE) ? csr_rvalue : r_result;

  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  // Count every commit that does not raise an exception; wraps at 2^64.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_retire_cnt <= 64'd0;
    else if (w_commit && !w_exc_any)
      r_retire_cnt <= r_retire_cnt + 64'd1;
  end

  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: the driver predicts stage occupancy
// and per-instruction results and queues expectations; a monitor pops one
// expectation per visible retirement (rf_we / wb_ex / ertn_flush).
module tb_wb_commit_stage;
  localparam int PC_W    = 32;
  localparam int NUM_EXC = 6;
  localparam int CSR_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              ms_to_ws_valid, ws_allowin;
  logic [PC_W-1:0]   ms_pc, ms_result, ms_vaddr, ms_rj, ms_rkd;
  logic [4:0]        ms_dest;
  logic              ms_gr_we, ms_ertn;
  logic [NUM_EXC-1:0] ms_exc;
  logic [1:0]        ms_csr_op;
  logic [13:0]       ms_csr_num;
  logic              csr_re, csr_we;
  logic [13:0]       csr_num;
  logic [PC_W-1:0]   csr_wmask, csr_wvalue, csr_rvalue;
  logic              wb_ex, ertn_flush;
  logic [5:0]        wb_ecode;
  logic [8:0]        wb_esubcode;
  logic [PC_W-1:0]   wb_pc, wb_vaddr;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [PC_W-1:0]   rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]        debug_wb_rf_we;
  logic [4:0]        debug_wb_rf_wnum;
  logic [63:0]       retire_cnt;

  wb_commit_stage #(.PC_W(PC_W), .NUM_EXC(NUM_EXC), .CSR_LAT(CSR_LAT)) dut (
    .clk(clk), .reset(rst),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_vaddr(ms_vaddr),
    .ms_dest(ms_dest), .ms_gr_we(ms_gr_we), .ms_exc(ms_exc), .ms_ertn(ms_ertn),
    .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num), .ms_rj(ms_rj), .ms_rkd(ms_rkd),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt)
  );

  // CSR file stand-in: CSR 5 holds 0x1234, others a hash of the number.
  function automatic logic [31:0] csr_val(input logic [13:0] n);
    csr_val = (n == 14'h5) ? 32'h0000_1234 : (32'hA5A5_0000 ^ {18'h0, n});
  endfunction
  assign csr_rvalue = csr_val(csr_num);

  typedef struct {
    logic [31:0] pc, result, vaddr, rj, rkd;
    logic [4:0]  dest;
    logic        gr_we, ertn;
    logic [5:0]  exc;
    logic [1:0]  op;
    logic [13:0] num;
  } instr_t;

  typedef struct {
    logic        ex, ertn_f, rf_we, csr_we, csr_re;
    logic [5:0]  ecode;
    logic [31:0] pc, vaddr, wdata, wmask, wvalue;
    logic [4:0]  dest;
    logic [13:0] num;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference occupancy model.
  bit occ, occ_flush, occ_ex;
  int stall;
  logic [63:0] retire_exp;

  logic [5:0] ecode_tab [6] = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input instr_t in);
    exp_t e;
    bit found = 0;
    e.ex = |in.exc;
    e.ecode = 6'h00;
    for (int b = 0; b < 6; b++)
      if (in.exc[b] && !found) begin e.ecode = ecode_tab[b]; found = 1; end
    e.ertn_f = !e.ex && in.ertn;
    e.rf_we  = in.gr_we && !e.ex;
    e.num    = in.ertn ? 14'h6 : in.num;
    e.csr_re = (in.op != 2'b00) || in.ertn;
    e.wdata  = (in.op != 2'b00) ? csr_val(e.num) : in.result;
    e.csr_we = !e.ex && (in.op == 2'b10 || in.op == 2'b11);
    e.wmask  = (in.op == 2'b10) ? 32'hFFFF_FFFF : in.rj;
    e.wvalue = in.rkd;
    e.pc = in.pc; e.vaddr = in.vaddr; e.dest = in.dest;
    return e;
  endfunction

  function automatic instr_t nop_i();
    instr_t r;
    r.pc = 0; r.result = 0; r.vaddr = 0; r.rj = 0; r.rkd = 0; r.dest = 0;
    r.gr_we = 1; r.ertn = 0; r.exc = 0; r.op = 0; r.num = 0;
    return r;
  endfunction

  function automatic instr_t rnd_i();
    instr_t r = nop_i();
    int k = int'($urandom_range(0, 7));
    r.pc = $urandom; r.result = $urandom; r.vaddr = $urandom;
    r.rj = $urandom; r.rkd = $urandom; r.dest = 5'($urandom);
    r.num = 14'($urandom_range(0, 15));
    case (k)
      4, 5: r.op = 2'($urandom_range(1, 3));
      6: begin r.exc = 6'($urandom_range(1, 63)); r.op = 2'($urandom); r.gr_we = 1'($urandom); end
      7: begin r.ertn = 1; r.gr_we = 0; end
      default: ;
    endcase
    return r;
  endfunction

  // One cycle: drive at negedge, check handshake, advance model, clock.
  task automatic step(input bit v, input instr_t in, output bit consumed);
    bit pred, flush;
    ms_to_ws_valid = v;
    ms_pc = in.pc; ms_result = in.result; ms_vaddr = in.vaddr;
    ms_rj = in.rj; ms_rkd = in.rkd; ms_dest = in.dest; ms_gr_we = in.gr_we;
    ms_exc = in.exc; ms_ertn = in.ertn; ms_csr_op = in.op; ms_csr_num = in.num;
    pred = !occ || stall == 0;
    chk("ws_allowin", 64'(ws_allowin), 64'(pred));
    consumed = v && pred;
    if (pred) begin
      flush = occ && occ_flush;
      if (occ && !occ_ex) retire_exp++;
      if (v && !flush) begin
        occ = 1;
        occ_ex = |in.exc;
        occ_flush = occ_ex || in.ertn;
        stall = (in.op != 2'b00 && !occ_ex) ? CSR_LAT : 0;
        sbq.push_back(model(in));
      end else begin
        occ = 0;
      end
    end else begin
      stall--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input instr_t in);
    bit c = 0;
    int n = 0;
    while (!c && n < 10) begin step(1'b1, in, c); n++; end
    if (!c) begin
      vectors++; miscompares++;
      $display("FAIL offer_timeout: instruction pc=%0h never accepted", in.pc);
    end
  endtask

  task automatic idle(input int n);
    bit c;
    for (int i = 0; i < n; i++) step(1'b0, nop_i(), c);
  endtask

  // Monitor: every visible retirement must match the oldest expectation.
  exp_t me;
  always @(negedge clk) begin
    if (rst === 1'b0 && (rf_we || wb_ex || ertn_flush)) begin
      if (sbq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_commit: pc=%0h rf_we=%0b wb_ex=%0b ertn=%0b expected none",
                 debug_wb_pc, rf_we, wb_ex, ertn_flush);
      end else begin
        me = sbq.pop_front();
        chk("wb_ex", 64'(wb_ex), 64'(me.ex));
        chk("ertn_flush", 64'(ertn_flush), 64'(me.ertn_f));
        chk("rf_we", 64'(rf_we), 64'(me.rf_we));
        chk("debug_wb_rf_we", 64'(debug_wb_rf_we), 64'({4{me.rf_we}}));
        chk("debug_wb_pc", 64'(debug_wb_pc), 64'(me.pc));
        chk("csr_we", 64'(csr_we), 64'(me.csr_we));
        chk("csr_re", 64'(csr_re), 64'(me.csr_re));
        if (me.csr_re) chk("csr_num", 64'(csr_num), 64'(me.num));
        if (me.ex) begin
          chk("wb_ecode", 64'(wb_ecode), 64'(me.ecode));
          chk("wb_esubcode", 64'(wb_esubcode), 64'h0);
          chk("wb_pc", 64'(wb_pc), 64'(me.pc));
          chk("wb_vaddr", 64'(wb_vaddr), 64'(me.vaddr));
        end
        if (me.rf_we) begin
          chk("rf_waddr", 64'(rf_waddr), 64'(me.dest));
          chk("rf_wdata", 64'(rf_wdata), 64'(me.wdata));
          chk("debug_wb_rf_wnum", 64'(debug_wb_rf_wnum), 64'(me.dest));
          chk("debug_wb_rf_wdata", 64'(debug_wb_rf_wdata), 64'(me.wdata));
        end
        if (me.csr_we) begin
          chk("csr_wmask", 64'(csr_wmask), 64'(me.wmask));
          chk("csr_wvalue", 64'(csr_wvalue), 64'(me.wvalue));
        end
      end
    end
  end

  task automatic model_reset();
    occ = 0; occ_flush = 0; occ_ex = 0; stall = 0; retire_exp = 64'd0;
    sbq.delete();
  endtask

  instr_t t;
  logic [63:0] rc_exp;

  initial begin
    rst = 1'b1;
    ms_to_ws_valid = 0; ms_pc = 0; ms_result = 0; ms_vaddr = 0; ms_rj = 0; ms_rkd = 0;
    ms_dest = 0; ms_gr_we = 0; ms_exc = 0; ms_ertn = 0; ms_csr_op = 0; ms_csr_num = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_allowin", 64'(ws_allowin), 64'h1);
    chk("reset_rf_we", 64'(rf_we), 64'h0);
    chk("reset_wb_ex", 64'(wb_ex), 64'h0);
    chk("reset_csr_we", 64'(csr_we), 64'h0);
    chk("reset_ertn_flush", 64'(ertn_flush), 64'h0);
    chk("reset_retire_cnt", retire_cnt, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // csrrd CSR 5, two-cycle read latency
    t = nop_i(); t.op = 2'b01; t.num = 14'h5; t.dest = 5'd7; t.pc = 32'h1C00_0000;
    offer(t);
    idle(4);

    // SYS exception; the instruction offered right behind it is dropped
    t = nop_i(); t.exc = 6'b001000; t.pc = 32'h1C00_0100; t.vaddr = 32'h0BAD_0000;
    offer(t);
    t = nop_i(); t.pc = 32'h1C00_0104; t.result = 32'hDEAD_BEEF; t.dest = 5'd3;
    offer(t);
    idle(2);

    // ADEF outranks INE
    t = nop_i(); t.exc = 6'b000110; t.pc = 32'h1C00_0200;
    offer(t);
    idle(2);

    // csrxchg
    t = nop_i(); t.op = 2'b11; t.num = 14'h4; t.rj = 32'h0F0; t.rkd = 32'hABC; t.dest = 5'd9;
    offer(t);
    idle(4);

    // csrwr, then ertn (reads ERA)
    t = nop_i(); t.op = 2'b10; t.num = 14'h1; t.rkd = 32'h55; t.dest = 5'd2;
    offer(t);
    t = nop_i(); t.ertn = 1; t.gr_we = 0; t.pc = 32'h1C00_0300;
    offer(t);
    idle(3);

    // reset while a CSR read is waiting
    t = nop_i(); t.op = 2'b01; t.num = 14'h8; t.dest = 5'd4;
    offer(t);
    #2 rst = 1'b1;
    ms_to_ws_valid = 0;
    #1;
    chk("midreset_allowin", 64'(ws_allowin), 64'h1);
    chk("midreset_csr_we", 64'(csr_we), 64'h0);
    chk("midreset_rf_we", 64'(rf_we), 64'h0);
    chk("midreset_csr_re", 64'(csr_re), 64'h0);
    chk("midreset_retire_cnt", retire_cnt, 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // 100 back-to-back ALU instructions
    for (int i = 0; i < 100; i++) begin
      t = nop_i(); t.pc = 32'h1C00_1000 + 32'(4 * i); t.result = $urandom; t.dest = 5'($urandom);
      offer(t);
    end
    idle(2);
`ifdef WB_RETIRE_CNT_EN
    rc_exp = 64'd100;
`else
    rc_exp = 64'd0;
`endif
    chk("retire_cnt_after_100", retire_cnt, rc_exp);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else offer(rnd_i());
    end
    idle(6);
`ifdef WB_RETIRE_CNT_EN
    rc_exp = retire_exp;
`else
    rc_exp = 64'd0;
`endif
    chk("retire_cnt_final", retire_cnt, rc_exp);
    chk("scoreboard_drained", 64'(sbq.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
